hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the ID stage and drives the write enables of the PC and the IF/ID, ID/EX and EX/MEM registers. It also drives the flush/bubble selects that feed the ID/EX control-zeroing 1-bit 2:1 muxes (s=1 selects the zero input). It handles load-use stalls, taken-branch flushes and variable-latency data-memory freezes, and keeps saturating performance counters plus a sticky memory-timeout halt.

## Interface
- CNT_W, 16: width of the performance counters
- TIMEOUT, 255: number of consecutive memory-wait cycles that triggers a halt (1..2^TO_W-1)
- TO_W, 8: width of the wait counter

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- id_rs, id_rt  input  5 each  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  input  1 each  instruction in ID reads rs / rt
- ex_mem_read  input  1  instruction in EX is a load
- ex_rt  input  5  destination register of the load in EX
- ex_branch_taken  input  1  branch/jump in EX resolved taken
- mem_req  input  1  MEM stage has an active data-memory access
- mem_ready  input  1  data memory completes the access this cycle
- pc_we, ifid_we, idex_we, exmem_we  output  1 each  register write enables
- ifid_flush  output  1  IF/ID loads a NOP
- bubble_sel  output  1  select for the ID/EX control-zeroing muxes (1 = bubble)
- memwb_bubble  output  1  MEM/WB loads a bubble
- lu_stall_cnt  output  CNT_W  load-use stall cycles, saturating
- flush_cnt  output  CNT_W  branch flush events, saturating
- mem_timeout  output  1  sticky: the controller is in HALT

## Operation
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: memory freeze in progress.
  - HALT: terminal until reset.
- Terms:
  - lu = ex_mem_read & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt))
  - mfrz = mem_req & ~mem_ready
  - freeze = mfrz | (state == HALT)
- Output priority, evaluated as a Mealy function of the state and current inputs:
  - Priority 1, freeze: all four write enables = 0, memwb_bubble = 1, ifid_flush = 0, bubble_sel = 0.
  - Priority 2, ex_branch_taken: all write enables = 1, ifid_flush = 1, bubble_sel = 1. lu is ignored because the ID instruction is squashed.
  - Priority 3, lu: pc_we = 0, ifid_we = 0, idex_we = 1, exmem_we = 1, bubble_sel = 1.
  - Otherwise: all write enables = 1, all flush/bubble outputs = 0.
- Transitions:
  - RUN → MEM_WAIT when mfrz.
  - MEM_WAIT → RUN when ~mfrz.
  - MEM_WAIT → HALT when mfrz and wait_cnt == TIMEOUT-1.
  - HALT → HALT until rst_n is asserted.
- wait_cnt:
  - Clears to 0 on every edge where mfrz = 0.
  - Otherwise increments by 1.
  - Holds its value in HALT.
- lu_stall_cnt increments on an edge where the priority-3 condition was active. flush_cnt increments on an edge where the priority-2 condition was active. Both saturate at 2^CNT_W-1 and never wrap.
- mem_timeout = (state == HALT).

## Timing
- Reset (rst_n = 0, asynchronous):
  - state = RUN; wait_cnt, lu_stall_cnt, flush_cnt = 0; mem_timeout = 0.
  - With idle inputs, the outputs read we = 1 and flush/bubble = 0.
- Control outputs are combinational, with zero cycles of latency from inputs. The state and counters update on the rising edge of clk.
- A load-use stall lasts exactly 1 cycle. On the next edge the load advances to MEM and lu drops without any FSM involvement.
- The freeze is active in the same cycle as mfrz. In the cycle mem_ready = 1, the pipeline advances.
- Simultaneous freeze and branch: the freeze wins. The branch stays in EX (EX/MEM is frozen) and flushes on the first unfrozen cycle.
- Counting to HALT: mfrz held for TIMEOUT consecutive cycles means the state is HALT after the TIMEOUT-th edge. From then on the pipeline stays frozen regardless of mem_ready.
- Reset asserted mid-freeze or in HALT immediately returns the block to the reset values.

## Test plan
- Load-use: ex_mem_read = 1, ex_rt = 5, id_rs = 5, id_use_rs = 1 → pc_we = 0, ifid_we = 0, bubble_sel = 1 for exactly 1 cycle; lu_stall_cnt 0 → 1. Repeat with ex_rt = 0 → no stall.
- Branch vs load-use in the same cycle: ex_branch_taken = 1 and lu = 1 → ifid_flush = 1, bubble_sel = 1, pc_we = 1; flush_cnt +1; lu_stall_cnt unchanged.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then mem_ready = 1 → all we = 0 and memwb_bubble = 1 for 3 cycles; state returns to RUN; wait_cnt = 0.
- Timeout: TIMEOUT = 4, mfrz held for 4 cycles → mem_timeout = 1 after the 4th edge; it stays 1 with mem_ready = 1 and clears only on rst_n = 0.
- Saturation: CNT_W = 4, 20 load-use cycles → lu_stall_cnt = 15, held.
- Async reset mid-MEM_WAIT: assert rst_n = 0 between clock edges → the counters and the state clear immediately; with inputs idle the outputs read we = 1.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/stall controller.
// master = pipeline datapath, slave = controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             exmem_we;
  logic             ifid_flush;
  logic             bubble_sel;
  logic             memwb_bubble;
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, bubble_sel, memwb_bubble,
           lu_stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt, ex_branch_taken,
           mem_req, mem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, bubble_sel, memwb_bubble,
           lu_stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Five-stage pipeline hazard/stall controller: load-use stalls, branch flushes,
// data-memory freezes with a sticky timeout halt, and saturating event counters.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StHalt
  } state_e;

  localparam logic [TO_W-1:0]  WaitLast = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs_hit, rt_hit, lu, mfrz, halted, freeze;
  logic br_flush, lu_stall;

  assign rs_hit   = bus.id_use_rs & (bus.id_rs == bus.ex_rt);
  assign rt_hit   = bus.id_use_rt & (bus.id_rt == bus.ex_rt);
  // r0 is hardwired to zero, so a load "into" it never creates a dependency.
  assign lu       = bus.ex_mem_read & (bus.ex_rt != 5'd0) & (rs_hit | rt_hit);
  assign mfrz     = bus.mem_req & ~bus.mem_ready;
  assign halted   = (state_q == StHalt);
  assign freeze   = mfrz | halted;
  // The squashed ID instruction cannot cause a hazard, so a branch masks lu.
  assign br_flush = ~freeze & bus.ex_branch_taken;
  assign lu_stall = ~freeze & ~bus.ex_branch_taken & lu;

  always_comb begin
    bus.pc_we        = 1'b1;
    bus.ifid_we      = 1'b1;
    bus.idex_we      = 1'b1;
    bus.exmem_we     = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.bubble_sel   = 1'b0;
    bus.memwb_bubble = 1'b0;
    if (freeze) begin
      bus.pc_we        = 1'b0;
      bus.ifid_we      = 1'b0;
      bus.idex_we      = 1'b0;
      bus.exmem_we     = 1'b0;
      bus.memwb_bubble = 1'b1;
    end else if (bus.ex_branch_taken) begin
      bus.ifid_flush = 1'b1;
      bus.bubble_sel = 1'b1;
    end else if (lu) begin
      bus.pc_we      = 1'b0;
      bus.ifid_we    = 1'b0;
      bus.bubble_sel = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRun, StMemWait: begin
        if (!mfrz) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + 1'b1;
          state_d = (wait_q == WaitLast) ? StHalt : StMemWait;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu_stall && (lu_cnt_q != CntMax)) begin
      lu_cnt_d = lu_cnt_q + 1'b1;
    end
    if (br_flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_q      <= '0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.lu_stall_cnt = lu_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
  assign bus.mem_timeout  = halted;

endmodule
